// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle core control path: opcodes, FSM
// state codes, datapath mux selects and the bundled control vector.
package multicycle_ctrl_pkg;

  // Opcode values as they appear in the IR opcode field
  localparam logic [3:0] OP_ALU_R = 4'h0;
  localparam logic [3:0] OP_ALU_I = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_JUMP  = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // State codes are visible on state_o, so the encoding is fixed
  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_EXEC_R = 4'h2,
    S_EXEC_I = 4'h3,
    S_MEMADR = 4'h4,
    S_MEMRD  = 4'h5,
    S_MEMWB  = 4'h6,
    S_MEMWR  = 4'h7,
    S_ALUWB  = 4'h8,
    S_BRANCH = 4'h9,
    S_JUMP   = 4'hA,
    S_HALT   = 4'hB
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG = 2'd0;
  localparam logic [1:0] SRCB_ONE = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Every control output the FSM drives, bundled for the decoder
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_en;
    logic       pc_en;
    logic       data_en;
    logic       aluout_en;
    logic       rf_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       wb_src;
    logic       halted;
  } ctrl_t;

  // Quiet control vector: nothing enabled, every mux on its zero leg
  function automatic ctrl_t ctrl_idle();
    return '0;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decoder: maps the current state (plus the two
// Mealy inputs mem_ready and zero) onto the full control vector.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  // Start from the idle vector and switch on only what each state needs
  always_comb begin
    ctrl = ctrl_idle();
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_ONE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_ALU;
        ctrl.ir_en     = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        // branch target is precomputed here so BRANCH only has to compare
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.aluout_en = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
        ctrl.aluout_en = 1'b1;
      end
      S_EXEC_I, S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.aluout_en = 1'b1;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.data_en = mem_ready;
      end
      S_MEMWB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_src = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_ALUWB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_src = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PC_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_en  = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core. Holds only the state register
// and next-state logic; all outputs come from multicycle_ctrl_decode.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int ALUOPW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPW-1:0]    opcode,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              iord,
  output logic              ir_en,
  output logic              pc_en,
  output logic              data_en,
  output logic              aluout_en,
  output logic              rf_we,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [ALUOPW-1:0] alu_op,
  output logic [1:0]        pc_src,
  output logic              wb_src,
  output logic              halted,
  output logic [3:0]        state_o
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  // State register; async reset drops straight back to the fetch pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state logic; memory states hold until mem_ready, HALT holds forever
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPW'(OP_ALU_R): next_state = S_EXEC_R;
          OPW'(OP_ALU_I): next_state = S_EXEC_I;
          OPW'(OP_LOAD):  next_state = S_MEMADR;
          OPW'(OP_STORE): next_state = S_MEMADR;
          OPW'(OP_BEQ):   next_state = S_BRANCH;
          OPW'(OP_JUMP):  next_state = S_JUMP;
          OPW'(OP_HALT):  next_state = S_HALT;
          default:        next_state = S_FETCH;
        endcase
      end
      S_EXEC_R: next_state = S_ALUWB;
      S_EXEC_I: next_state = S_ALUWB;
      S_MEMADR: next_state = (opcode == OPW'(OP_STORE)) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_MEMWB:  next_state = S_FETCH;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  multicycle_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign mem_req   = ctrl.mem_req;
  assign mem_we    = ctrl.mem_we;
  assign iord      = ctrl.iord;
  assign ir_en     = ctrl.ir_en;
  assign pc_en     = ctrl.pc_en;
  assign data_en   = ctrl.data_en;
  assign aluout_en = ctrl.aluout_en;
  assign rf_we     = ctrl.rf_we;
  assign alu_src_a = ctrl.alu_src_a;
  assign alu_src_b = ctrl.alu_src_b;
  assign alu_op    = ALUOPW'(ctrl.alu_op);
  assign pc_src    = ctrl.pc_src;
  assign wb_src    = ctrl.wb_src;
  assign halted    = ctrl.halted;
  assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: an instruction-path model predicts the
// state and every output each cycle, plus directed literal expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_en, pc_en, data_en, aluout_en, rf_we;
  logic       alu_src_a, wb_src, halted;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_en;
    logic       pc_en;
    logic       data_en;
    logic       aluout_en;
    logic       rf_we;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       wb_src;
    logic       halted;
  } outv_t;

  outv_t act;
  outv_t spec_rows [12];
  bit    model_live = 1'b0;
  int    exp_state = 0;
  int    path [$];

  assign act = {mem_req, mem_we, iord, ir_en, pc_en, data_en, aluout_en, rf_we,
                alu_src_a, alu_src_b, alu_op, pc_src, wb_src, halted};

  multicycle_ctrl #(.OPW(4), .ALUOPW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .iord      (iord),
    .ir_en     (ir_en),
    .pc_en     (pc_en),
    .data_en   (data_en),
    .aluout_en (aluout_en),
    .rf_we     (rf_we),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .pc_src    (pc_src),
    .wb_src    (wb_src),
    .halted    (halted),
    .state_o   (state_o)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic outv_t row(input int mreq, input int mwe, input int io, input int pce,
                                input int aoe, input int rfw, input int sa, input int sb,
                                input int op, input int ps, input int wb, input int h);
    outv_t e;
    e = '0;
    e.mem_req = mreq[0]; e.mem_we = mwe[0]; e.iord = io[0]; e.pc_en = pce[0];
    e.aluout_en = aoe[0]; e.rf_we = rfw[0]; e.alu_src_a = sa[0];
    e.alu_src_b = sb[1:0]; e.alu_op = op[1:0]; e.pc_src = ps[1:0];
    e.wb_src = wb[0]; e.halted = h[0];
    return e;
  endfunction

  function automatic outv_t expect_out(input int s, input logic mr, input logic z);
    outv_t e;
    e = spec_rows[s];
    if (s == 0) begin e.ir_en = mr; e.pc_en = mr; end
    if (s == 5) e.data_en = mr;
    if (s == 9) e.pc_en = z;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Instruction-path model: each opcode expands to its list of states,
  // with the memory states repeating while mem_ready is low
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_state = 0;
      path.delete();
    end else if ((exp_state == 0 || exp_state == 5 || exp_state == 7) && !mem_ready) begin
      exp_state = exp_state;
    end else if (exp_state == 11) begin
      exp_state = 11;
    end else if (exp_state == 0) begin
      case (opcode)
        4'h0:    path = '{1, 2, 8};
        4'h1:    path = '{1, 3, 8};
        4'h2:    path = '{1, 4, 5, 6};
        4'h3:    path = '{1, 4, 7};
        4'h4:    path = '{1, 9};
        4'h5:    path = '{1, 10};
        4'hF:    path = '{1, 11};
        default: path = '{1};
      endcase
      exp_state = path.pop_front();
    end else if (path.size() == 0) begin
      exp_state = 0;
    end else begin
      exp_state = path.pop_front();
    end
  end

  // Every falling edge: DUT state and full output vector against the model
  always @(negedge clk) begin
    if (model_live) begin
      checkOutput("model_state", 64'(state_o), 64'(exp_state));
      checkOutput("model_outputs", 64'(act), 64'(expect_out(exp_state, mem_ready, zero)));
    end
  end

  logic [63:0] seq;
  outv_t       probe_v;
  int cnt_fetch_en, cnt_rf, cnt_memwe, cnt_data, cnt_wr, cnt_memrd_req;
  int cnt_halt, cnt_halt_en;

  task automatic applyStimulus(input logic mr, input logic z);
    @(posedge clk);
    #2;
    mem_ready = mr;
    zero = z;
    @(negedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [3:0] op, input logic z, input int n,
                          input logic [31:0] mask, input int probe);
    opcode = op;
    seq = '0;
    cnt_fetch_en = 0; cnt_rf = 0; cnt_memwe = 0; cnt_data = 0; cnt_wr = 0;
    cnt_memrd_req = 0; cnt_halt = 0; cnt_halt_en = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(mask[i], z);
      seq = {seq[59:0], state_o};
      if (i == probe) probe_v = act;
      if (ir_en || pc_en) if (state_o == 4'h0) cnt_fetch_en++;
      if (rf_we) cnt_rf++;
      if (mem_we) cnt_memwe++;
      if (data_en) cnt_data++;
      if (rf_we || mem_we || data_en) cnt_wr++;
      if (state_o == 4'h5 && mem_req && iord) cnt_memrd_req++;
      if (state_o == 4'hB) begin
        if (halted) cnt_halt++;
        if (ir_en || pc_en || data_en || aluout_en || rf_we || mem_req || mem_we) cnt_halt_en++;
      end
    end
  endtask

  initial begin
    spec_rows[0]  = row(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    spec_rows[1]  = row(0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
    spec_rows[2]  = row(0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0);
    spec_rows[3]  = row(0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    spec_rows[4]  = row(0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0);
    spec_rows[5]  = row(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    spec_rows[6]  = row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    spec_rows[7]  = row(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    spec_rows[8]  = row(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    spec_rows[9]  = row(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    spec_rows[10] = row(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    spec_rows[11] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_live = 1'b1;

    @(negedge clk);
    #1;
    checkOutput("reset_state", 64'(state_o), 64'h0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'h1);
    checkOutput("reset_iord", 64'(iord), 64'h0);
    checkOutput("reset_ir_en", 64'(ir_en), 64'h0);
    checkOutput("reset_rf_we", 64'(rf_we), 64'h0);
    checkOutput("reset_halted", 64'(halted), 64'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    runInstr(4'h0, 1'b0, 5, 32'h0F, -1);
    checkOutput("alu_r_states", seq, 64'h1280);
    checkOutput("alu_r_rf_we_count", 64'(cnt_rf), 64'd1);
    checkOutput("alu_r_fetch_en_count", 64'(cnt_fetch_en), 64'd1);

    runInstr(4'h1, 1'b0, 5, 32'h0F, -1);
    checkOutput("alu_i_states", seq, 64'h1380);

    runInstr(4'h2, 1'b0, 9, 32'hC7, 7);
    checkOutput("load_states", seq, 64'h14555560);
    checkOutput("load_req_hold", 64'(cnt_memrd_req), 64'd4);
    checkOutput("load_data_en_pulses", 64'(cnt_data), 64'd1);
    checkOutput("load_memwb_rf_we", 64'(probe_v.rf_we), 64'h1);
    checkOutput("load_memwb_wb_src", 64'(probe_v.wb_src), 64'h1);

    runInstr(4'h3, 1'b0, 5, 32'h0F, -1);
    checkOutput("store_states", seq, 64'h1470);
    checkOutput("store_mem_we_count", 64'(cnt_memwe), 64'd1);

    runInstr(4'h4, 1'b1, 4, 32'h07, 2);
    checkOutput("beq_taken_states", seq, 64'h190);
    checkOutput("beq_taken_pc_en", 64'(probe_v.pc_en), 64'h1);
    checkOutput("beq_taken_pc_src", 64'(probe_v.pc_src), 64'h1);

    runInstr(4'h4, 1'b0, 4, 32'h07, 2);
    checkOutput("beq_not_taken_states", seq, 64'h190);
    checkOutput("beq_not_taken_pc_en", 64'(probe_v.pc_en), 64'h0);

    runInstr(4'h5, 1'b0, 4, 32'h07, 2);
    checkOutput("jump_states", seq, 64'h1A0);
    checkOutput("jump_pc_src", 64'(probe_v.pc_src), 64'h2);

    runInstr(4'h7, 1'b0, 3, 32'h03, -1);
    checkOutput("illegal_states", seq, 64'h010);
    checkOutput("illegal_write_pulses", 64'(cnt_wr), 64'd0);

    runInstr(4'hF, 1'b0, 22, 32'h0015_5557, -1);
    checkOutput("halt_state", 64'(state_o), 64'hB);
    checkOutput("halt_cycles", 64'(cnt_halt), 64'd20);
    checkOutput("halt_enables", 64'(cnt_halt_en), 64'd0);

    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;

    runInstr(4'h3, 1'b0, 4, 32'h07, 3);
    checkOutput("memwr_states", seq, 64'h147);
    checkOutput("memwr_mem_we", 64'(probe_v.mem_we), 64'h1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_state", 64'(state_o), 64'h0);
    checkOutput("async_reset_mem_we", 64'(mem_we), 64'h0);
    checkOutput("async_reset_iord", 64'(iord), 64'h0);
    checkOutput("async_reset_mem_req", 64'(mem_req), 64'h1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("post_reset_state", 64'(state_o), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
